led_arbiter: RTL and testbench

Shares one RGB LED between up to NUM_REQ status sources (reset indicator, heartbeat, software, error) with round-robin arbitration, a minimum display hold and per-requester colour, brightness and blink. Sits between the LED-producing logic in the FPGA top level and the board RGB pins, replacing direct per-source LED wiring. Brightness uses an internal PWM comparator of the same width as the existing LED PWM duty cycle (11 bits).

---
 rtl/led_pkg.sv | 25 ++
 rtl/led_rr_pick.sv | 45 ++++
 rtl/led_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_led_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - Shared types and constants for the LED arbiter family
//
// Purpose: FSM state encoding, default timing/width constants and RGB bit
//          positions shared by led_arbiter and its helpers.
// Ports:   none (package).
package led_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      SHOW = 2'd2,
      GAP  = 2'd3
   } led_state_t;

   localparam int DEF_DUTY_W       = 11;
   localparam int DEF_HOLD_CYCLES  = 50_000_000;
   localparam int DEF_BLINK_CYCLES = 25_000_000;

   // Colour triplets are packed {r,g,b}
   localparam int RGB_W = 3;
   localparam int RGB_R = 2;
   localparam int RGB_G = 1;
   localparam int RGB_B = 0;

endpackage

// File: rtl/led_rr_pick.sv
// rtl/led_rr_pick.sv - Combinational round-robin picker for shared-resource arbiters
//
// Purpose: scans req starting at rr_ptr, wrapping at N-1, and reports the
//          first set request.
// Ports:
//   req     in  N      request vector
//   rr_ptr  in  PTR_W  highest-priority index for this pick (must be < N)
//   onehot  out N      one-hot winner (zero when nothing requests)
//   idx     out PTR_W  winner index
//   valid   out 1      any request set
module led_rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     onehot,
   output logic [PTR_W-1:0] idx,
   output logic             valid
);

   logic [PTR_W:0] cand;

   // Walk offsets from farthest to nearest so the nearest set request,
   // evaluated last, overrides any earlier hit.
   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int off = N - 1; off >= 0; off--) begin
         cand = {1'b0, rr_ptr} + (PTR_W + 1)'(off);
         if (cand >= (PTR_W + 1)'(N)) begin
            cand = cand - (PTR_W + 1)'(N);
         end
         if (req[cand[PTR_W-1:0]]) begin
            onehot                   = '0;
            onehot[cand[PTR_W-1:0]] = 1'b1;
            idx                      = cand[PTR_W-1:0];
            valid                    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - Round-robin sharing of one RGB LED between status sources
//
// Purpose: grants the LED to one requester at a time with a minimum display
//          hold, latching that source's colour, PWM brightness and blink mode.
// Build option: LED_ARBITER_BLINK_EN enables per-source blink; when undefined
//               blink inputs are ignored and no blink counter is built.
// Ports:
//   clk     in  1               system clock
//   rst     in  1               asynchronous active-high reset
//   req     in  NUM_REQ         level request per source
//   color   in  3*NUM_REQ       {r,g,b} per source, source i at [3i+2:3i]
//   duty    in  DUTY_W*NUM_REQ  brightness per source
//   blink   in  NUM_REQ         blink enable per source
//   gnt     out NUM_REQ         registered one-hot grant
//   busy    out 1               high in ARB, SHOW and GAP
//   led_r/g/b out 1             registered LED drive
module led_arbiter
   import led_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DUTY_W       = DEF_DUTY_W,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int BLINK_CYCLES = DEF_BLINK_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [RGB_W*NUM_REQ-1:0]  color,
   input  logic [DUTY_W*NUM_REQ-1:0] duty,
   input  logic [NUM_REQ-1:0]        blink,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      busy,
   output logic                      led_r,
   output logic                      led_g,
   output logic                      led_b
);

   localparam int PTR_W  = $clog2(NUM_REQ);
   localparam int HOLD_W = $clog2(HOLD_CYCLES);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("led_arbiter: NUM_REQ must be 2..8");
   end
   if (HOLD_CYCLES < 2) begin : g_bad_hold
      $error("led_arbiter: HOLD_CYCLES must be >= 2");
   end

   led_state_t          state;
   logic [NUM_REQ-1:0]  req_q;
   logic [PTR_W-1:0]    rr_ptr;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [RGB_W-1:0]    color_l;
   logic [DUTY_W-1:0]   duty_l;
   logic [DUTY_W-1:0]   pwm_cnt;
   logic                pwm_on;
   logic                blink_ph;

   logic [NUM_REQ-1:0]  pick_onehot;
   logic [PTR_W-1:0]    pick_idx;
   logic                pick_valid;
   logic [PTR_W-1:0]    next_ptr;
   logic [RGB_W-1:0]    win_color;
   logic [DUTY_W-1:0]   win_duty;
   logic                owner_req;
   logic                other_req;
   logic                hold_done;
   logic                show_entry;

   led_rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req    (req_q),
      .rr_ptr (rr_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   always_comb begin
      win_color = '0;
      win_duty  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_onehot[i]) begin
            win_color = color[RGB_W*i +: RGB_W];
            win_duty  = duty[DUTY_W*i +: DUTY_W];
         end
      end
   end

   assign next_ptr   = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
   // gnt is the one-hot owner while in SHOW, so it splits req into owner/others
   assign owner_req  = |(req_q & gnt);
   assign other_req  = |(req_q & ~gnt);
   assign hold_done  = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
   assign show_entry = (state == ARB) && pick_valid;
   assign pwm_on     = (pwm_cnt < duty_l);

   // Free-running PWM timebase; the FSM never restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

`ifdef LED_ARBITER_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_l;
   logic               win_blink;

   always_comb begin
      win_blink = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_onehot[i]) begin
            win_blink = blink[i];
         end
      end
   end

   // Phase restarts lit on every new grant; a non-blinking owner never toggles it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
         blink_l   <= 1'b0;
      end else if (show_entry) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b1;
         blink_l   <= win_blink;
      end else if (state == SHOW && blink_l) begin
         if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_blink;

   assign blink_ph     = 1'b1;
   assign unused_blink = ^blink;

   if (BLINK_CYCLES < 1) begin : g_bad_blink
      $error("led_arbiter: BLINK_CYCLES must be >= 1");
   end
`endif

   // req is registered once before the FSM sees it, giving ARB one cycle
   // after the first sampling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         req_q    <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         color_l  <= '0;
         duty_l   <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         led_r    <= 1'b0;
         led_g    <= 1'b0;
         led_b    <= 1'b0;
      end else begin
         req_q <= req;
         led_r <= (state == SHOW) & color_l[RGB_R] & pwm_on & blink_ph;
         led_g <= (state == SHOW) & color_l[RGB_G] & pwm_on & blink_ph;
         led_b <= (state == SHOW) & color_l[RGB_B] & pwm_on & blink_ph;

         case (state)
            IDLE: begin
               if (|req_q) begin
                  state <= ARB;
                  busy  <= 1'b1;
               end
            end
            ARB: begin
               if (pick_valid) begin
                  gnt      <= pick_onehot;
                  color_l  <= win_color;
                  duty_l   <= win_duty;
                  rr_ptr   <= next_ptr;
                  hold_cnt <= '0;
                  state    <= SHOW;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            SHOW: begin
               // An owner drop wins over a simultaneous hold expiry.
               if (!owner_req || (hold_done && other_req)) begin
                  gnt   <= '0;
                  state <= GAP;
               end else if (!hold_done) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            GAP: begin
               if (|req_q) begin
                  state <= ARB;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - Directed self-checking bench for led_arbiter
module tb_led_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [11:0] color;
   logic [15:0] duty;
   logic [3:0]  blink;
   logic [3:0]  gnt;
   logic        busy;
   logic        led_r;
   logic        led_g;
   logic        led_b;

   int n_checks = 0;
   int n_errors = 0;
   int ecnt;

   led_arbiter #(
      .NUM_REQ      (4),
      .DUTY_W       (4),
      .HOLD_CYCLES  (8),
      .BLINK_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .color (color),
      .duty  (duty),
      .blink (blink),
      .gnt   (gnt),
      .busy  (busy),
      .led_r (led_r),
      .led_g (led_g),
      .led_b (led_b)
   );

   always #5 clk = ~clk;

   // Edges since reset release: equals the free-running PWM count mod 16.
   always @(posedge clk or posedge rst) begin
      if (rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // PWM state used by the LED register at the most recent edge.
   function automatic bit pwm_prev(input int d);
      return ((ecnt - 1) & 15) < d;
   endfunction

   task automatic do_reset();
      req   = '0;
      color = '0;
      duty  = '0;
      blink = '0;
      rst   = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   logic [3:0] rr_exp [4];
   logic [2:0] rr_col [4];
   int         on_cnt;
   bit         ph;

   initial begin
      rst = 1'b1;
      rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      rr_col = '{3'b100, 3'b010, 3'b001, 3'b100};

      // Reset / idle
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step();
         check_val("idle_out", {gnt, busy, led_r, led_g, led_b}, 32'h0);
      end

      // Single requester, green at half duty, hold saturates
      color[8:6] = 3'b010;
      duty[11:8] = 4'd8;
      req        = 4'b0100;
      step();
      check_val("t0_busy", {gnt, busy}, 32'h0);
      step();
      check_val("arb_busy", {gnt, busy}, 32'h1);
      step();
      check_val("single_gnt", gnt, 32'h4);
      check_val("single_led_first", {led_r, led_g, led_b}, 32'h0);
      on_cnt = 0;
      for (int j = 0; j < 30; j++) begin
         step();
         check_val("single_hold_gnt", gnt, 32'h4);
         check_val("single_led", {led_r, led_g, led_b}, {29'd0, 1'b0, pwm_prev(8), 1'b0});
         if (j < 16 && led_g) on_cnt++;
      end
      check_val("single_on_count", on_cnt, 32'd8);

      // Asynchronous reset mid-grant
      #3;
      rst = 1'b1;
      #1;
      check_val("async_rst", {gnt, busy, led_r, led_g, led_b}, 32'h0);

      // Round robin over 1011
      do_reset();
      color = {3'b001, 3'b000, 3'b010, 3'b100};
      duty  = 16'hFFFF;
      req   = 4'b1011;
      step();
      step();
      for (int g = 0; g < 4; g++) begin
         for (int k = 0; k < 10; k++) begin
            step();
            check_val("rr_gnt", gnt, (k < 8) ? {28'd0, rr_exp[g]} : 32'h0);
            if (k >= 1 && k <= 8)
               check_val("rr_led", {led_r, led_g, led_b}, pwm_prev(15) ? {29'd0, rr_col[g]} : 32'h0);
            if (k == 0 || k == 9)
               check_val("rr_dark", {led_r, led_g, led_b}, 32'h0);
            if (k == 9)
               check_val("rr_gap_busy", busy, 32'h1);
         end
      end

      // Early release with mid-grant colour change
      do_reset();
      color = {3'b000, 3'b000, 3'b010, 3'b100};
      duty  = 16'hFFFF;
      req   = 4'b0011;
      step();
      step();
      step();
      check_val("early_gnt0", gnt, 32'h1);
      step();
      color[2:0] = 3'b001;
      step();
      check_val("latched_color", {led_r, led_g, led_b}, pwm_prev(15) ? 32'h4 : 32'h0);
      req = 4'b0010;
      step();
      check_val("drop_u_gnt", gnt, 32'h1);
      check_val("drop_u_led", {led_r, led_g, led_b}, pwm_prev(15) ? 32'h4 : 32'h0);
      step();
      check_val("drop_gap_gnt", gnt, 32'h0);
      check_val("drop_gap_led", {led_r, led_g, led_b}, pwm_prev(15) ? 32'h4 : 32'h0);
      step();
      check_val("drop_arb_gnt", gnt, 32'h0);
      check_val("drop_dark", {led_r, led_g, led_b}, 32'h0);
      step();
      check_val("next_owner", gnt, 32'h2);

      // Blink at full duty on source 1
      do_reset();
      color[5:3] = 3'b111;
      duty[7:4]  = 4'hF;
      blink      = 4'b0010;
      req        = 4'b0010;
      step();
      step();
      step();
      check_val("blink_gnt", gnt, 32'h2);
      for (int j = 1; j <= 24; j++) begin
`ifdef LED_ARBITER_BLINK_EN
         ph = (((j - 1) / 4) % 2) == 0;
`else
         ph = 1'b1;
`endif
         step();
         check_val("blink_led", {led_r, led_g, led_b}, (ph && pwm_prev(15)) ? 32'h7 : 32'h0);
      end

      // Zero duty never lights
      do_reset();
      color[5:3] = 3'b111;
      req        = 4'b0010;
      step();
      step();
      step();
      check_val("duty0_gnt", gnt, 32'h2);
      for (int j = 0; j < 20; j++) begin
         step();
         check_val("duty0_dark", {led_r, led_g, led_b}, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1);
   end

endmodule
